dcache_line_refill: RTL and testbench

DCACHE_LINE_REFILL -- requirements
Module: dcache_line_refill

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_line_refill_if.sv | 40 ++++
 rtl/dcache_line_refill.sv | 110 +++++++++++
 tb/tb_dcache_line_refill.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data-cache line refill path.
package dcache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned DCACHE_NUM_WORDS  = 256;
  localparam int unsigned REFILL_BEAT_WIDTH = 32;
  localparam int unsigned REFILL_BEATS      = DCACHE_LINE_WIDTH / REFILL_BEAT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } refill_state_t;

endpackage

// File: rtl/dcache_line_refill_if.sv
// Refill request / memory beat / data-store bundle around dcache_line_refill.
interface dcache_line_refill_if #(
  parameter int unsigned DATA_WIDTH = dcache_pkg::DCACHE_LINE_WIDTH,
  parameter int unsigned NUM_WORDS  = dcache_pkg::DCACHE_NUM_WORDS,
  parameter int unsigned BEAT_WIDTH = dcache_pkg::REFILL_BEAT_WIDTH
);
  localparam int unsigned BEATS  = DATA_WIDTH / BEAT_WIDTH;
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam int unsigned LANE_W = $clog2(BEATS);

  logic                    req_valid;
  logic                    req_ready;
  logic [IDX_W-1:0]        req_index;
  logic [LANE_W-1:0]       req_offset;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [BEAT_WIDTH-1:0]   mem_data;
  logic                    ds_en;
  logic                    ds_we;
  logic [IDX_W-1:0]        ds_addr;
  logic [DATA_WIDTH/8-1:0] ds_be;
  logic [DATA_WIDTH-1:0]   ds_wdata;
  logic                    crit_valid;
  logic [BEAT_WIDTH-1:0]   crit_data;
  logic                    done;

  // Requester / memory side.
  modport master (
    output req_valid, req_index, req_offset, mem_valid, mem_data,
    input  req_ready, mem_ready, ds_en, ds_we, ds_addr, ds_be, ds_wdata,
           crit_valid, crit_data, done
  );

  // Refill engine side.
  modport slave (
    input  req_valid, req_index, req_offset, mem_valid, mem_data,
    output req_ready, mem_ready, ds_en, ds_we, ds_addr, ds_be, ds_wdata,
           crit_valid, crit_data, done
  );
endinterface

// File: rtl/dcache_line_refill.sv
// Collects critical-beat-first memory beats into a line buffer, forwards the
// critical word, then writes the whole line into the data store in one cycle.
module dcache_line_refill
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = dcache_pkg::DCACHE_LINE_WIDTH,
  parameter int unsigned NUM_WORDS  = dcache_pkg::DCACHE_NUM_WORDS,
  parameter int unsigned BEAT_WIDTH = dcache_pkg::REFILL_BEAT_WIDTH
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [$clog2(NUM_WORDS)-1:0]             req_index_i,
  input  logic [$clog2(DATA_WIDTH/BEAT_WIDTH)-1:0] req_offset_i,
  input  logic                                     mem_valid_i,
  output logic                                     mem_ready_o,
  input  logic [BEAT_WIDTH-1:0]                    mem_data_i,
  output logic                                     ds_en_o,
  output logic                                     ds_we_o,
  output logic [$clog2(NUM_WORDS)-1:0]             ds_addr_o,
  output logic [DATA_WIDTH/8-1:0]                  ds_be_o,
  output logic [DATA_WIDTH-1:0]                    ds_wdata_o,
  output logic                                     crit_valid_o,
  output logic [BEAT_WIDTH-1:0]                    crit_data_o,
  output logic                                     done_o
);

  localparam int unsigned BEATS  = DATA_WIDTH / BEAT_WIDTH;
  localparam int unsigned LANE_W = $clog2(BEATS);
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);

  refill_state_t                  state_q, state_d;
  logic [LANE_W-1:0]              count_q;
  logic [LANE_W-1:0]              offset_q;
  logic [LANE_W-1:0]              lane;
  logic [IDX_W-1:0]               index_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q;
  logic                           req_hs;
  logic                           beat_hs;
  logic                           first_beat;
  logic                           last_beat;

  assign req_hs     = req_valid_i & req_ready_o;
  assign beat_hs    = mem_valid_i & mem_ready_o;
  assign first_beat = beat_hs && (count_q == '0);
  assign last_beat  = beat_hs && (count_q == LANE_W'(BEATS - 1));
  // Beats arrive critical-first, so the lane wraps around the line.
  assign lane       = offset_q + count_q;

  assign ds_addr_o  = index_q;
  assign ds_wdata_o = line_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_ready_o = 1'b0;
    ds_en_o     = 1'b0;
    ds_we_o     = 1'b0;
    ds_be_o     = '0;
    done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = FILL;
      end
      FILL: begin
        mem_ready_o = 1'b1;
        if (last_beat) state_d = WRITE;
      end
      WRITE: begin
        ds_en_o = 1'b1;
        ds_we_o = 1'b1;
        ds_be_o = '1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers that must come out of reset clean.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q      <= '0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
    end else begin
      crit_valid_o <= first_beat;
      if (first_beat) crit_data_o <= mem_data_i;
      if (req_hs)       count_q <= '0;
      else if (beat_hs) count_q <= count_q + LANE_W'(1);
    end
  end

  // Request capture and line buffer; contents are don't-care until filled.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      index_q  <= req_index_i;
      offset_q <= req_offset_i;
    end
    if (beat_hs) line_q[lane] <= mem_data_i;
  end

endmodule

// File: tb/tb_dcache_line_refill.sv
// Scoreboard bench for dcache_line_refill: drivers queue expected writes and
// critical words, a negedge monitor pops and compares them.
module tb_dcache_line_refill;

  localparam int unsigned DW = 128;
  localparam int unsigned NW = 256;
  localparam int unsigned BW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned LW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_line_refill_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .BEAT_WIDTH(BW)) bus ();

  dcache_line_refill #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .BEAT_WIDTH(BW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req_index_i  (bus.req_index),
    .req_offset_i (bus.req_offset),
    .mem_valid_i  (bus.mem_valid),
    .mem_ready_o  (bus.mem_ready),
    .mem_data_i   (bus.mem_data),
    .ds_en_o      (bus.ds_en),
    .ds_we_o      (bus.ds_we),
    .ds_addr_o    (bus.ds_addr),
    .ds_be_o      (bus.ds_be),
    .ds_wdata_o   (bus.ds_wdata),
    .crit_valid_o (bus.crit_valid),
    .crit_data_o  (bus.crit_data),
    .done_o       (bus.done)
  );

  typedef struct {
    logic [IW-1:0] addr;
    logic [DW-1:0] line;
    int            cyc;
  } wr_exp_t;

  typedef struct {
    logic [BW-1:0] data;
    int            cyc;
  } crit_exp_t;

  wr_exp_t   wr_q[$];
  crit_exp_t crit_q[$];
  wr_exp_t   wr_e;
  crit_exp_t crit_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every data-store write and critical-word pulse must match the queue head.
  always @(negedge clk) begin
    if (bus.ds_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", DW'(bus.ds_en), DW'(0));
      end else begin
        wr_e = wr_q.pop_front();
        check("ds_addr",   DW'(bus.ds_addr), DW'(wr_e.addr));
        check("ds_wdata",  bus.ds_wdata, wr_e.line);
        check("ds_be",     DW'(bus.ds_be), DW'(16'hFFFF));
        check("ds_we",     DW'(bus.ds_we), DW'(1));
        check("done",      DW'(bus.done), DW'(1));
        check("write_cyc", DW'(cyc), DW'(wr_e.cyc));
      end
    end else if (bus.done !== 1'b0 || bus.ds_we !== 1'b0 || bus.ds_be !== '0) begin
      check("quiet_outside_write", DW'({bus.done, bus.ds_we, bus.ds_be}), DW'(0));
    end
    if (bus.crit_valid === 1'b1) begin
      if (crit_q.size() == 0) begin
        check("unexpected_crit", DW'(bus.crit_valid), DW'(0));
      end else begin
        crit_e = crit_q.pop_front();
        check("crit_data", DW'(bus.crit_data), DW'(crit_e.data));
        check("crit_cyc",  DW'(cyc), DW'(crit_e.cyc));
      end
    end
  end

  task automatic issue_req(input logic [IW-1:0] idx, input logic [LW-1:0] off, input bit hold);
    int t;
    t = 0;
    bus.req_valid  = 1'b1;
    bus.req_index  = idx;
    bus.req_offset = off;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (bus.req_ready !== 1'b1) check("req_accept_timeout", DW'(bus.req_ready), DW'(1));
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Send beats[0..nbeats-1]; the first is the critical word.
  task automatic send_beats(input logic [IW-1:0] idx, input logic [3:0][BW-1:0] beats,
                            input int nbeats, input bit gap, input logic [DW-1:0] exp_line);
    int t;
    for (int i = 0; i < nbeats; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = beats[i];
      t = 0;
      while (bus.mem_ready !== 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      if (bus.mem_ready !== 1'b1) check("beat_accept_timeout", DW'(bus.mem_ready), DW'(1));
      @(posedge clk); #1;
      if (i == 0) crit_q.push_back('{beats[i], cyc});
      if (i == 3) wr_q.push_back('{idx, exp_line, cyc});
      bus.mem_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_index  = '0;
    bus.req_offset = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  DW'(bus.req_ready), DW'(1));
    check("rst_mem_ready",  DW'(bus.mem_ready), DW'(0));
    check("rst_crit_valid", DW'(bus.crit_valid), DW'(0));
    check("rst_crit_data",  DW'(bus.crit_data), DW'(0));
    check("rst_ds_en",      DW'(bus.ds_en), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Offset 0, back-to-back beats.
    issue_req(8'h12, 2'd0, 1'b0);
    send_beats(8'h12, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4, 1'b0,
               128'h44444444_33333333_22222222_11111111);
    repeat (2) @(posedge clk);
    #1;
    check("crit_hold", DW'(bus.crit_data), DW'(32'h11111111));

    // Offset 2, critical word lands in lane 2.
    issue_req(8'h34, 2'd2, 1'b0);
    send_beats(8'h34, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 4, 1'b0,
               128'hBBBBBBBB_AAAAAAAA_DDDDDDDD_CCCCCCCC);
    repeat (2) @(posedge clk);
    #1;

    // Offset 0 with idle gaps between beats.
    issue_req(8'h56, 2'd0, 1'b0);
    send_beats(8'h56, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4, 1'b1,
               128'h44444444_33333333_22222222_11111111);
    repeat (2) @(posedge clk);
    #1;

    // Reset after two beats aborts the refill.
    issue_req(8'h05, 2'd2, 1'b0);
    send_beats(8'h05, {32'h0, 32'h0, 32'hBEEF0002, 32'hBEEF0001}, 2, 1'b0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_req_ready",  DW'(bus.req_ready), DW'(1));
    check("abort_mem_ready",  DW'(bus.mem_ready), DW'(0));
    check("abort_crit_data",  DW'(bus.crit_data), DW'(0));
    check("abort_crit_valid", DW'(bus.crit_valid), DW'(0));
    repeat (3) @(posedge clk);
    #1;
    issue_req(8'h06, 2'd1, 1'b0);
    send_beats(8'h06, {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h89ABCDEF, 32'h01234567}, 4, 1'b0,
               128'h0F0F0F0F_89ABCDEF_01234567_F0F0F0F0);
    repeat (2) @(posedge clk);
    #1;

    // req_valid held high: second request taken the cycle after done; stray beats ignored.
    issue_req(8'h09, 2'd3, 1'b1);
    bus.req_index  = 8'h0A;
    bus.req_offset = 2'd0;
    send_beats(8'h09, {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, 4, 1'b0,
               128'h00000001_00000004_00000003_00000002);
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'hDEADBEEF;
    check("hold_ready_in_write", DW'(bus.req_ready), DW'(0));
    @(posedge clk); #1;
    check("hold_ready_idle",     DW'(bus.req_ready), DW'(1));
    check("mem_ready_idle",      DW'(bus.mem_ready), DW'(0));
    @(posedge clk); #1;
    check("second_accept",       DW'(bus.mem_ready), DW'(1));
    bus.req_valid = 1'b0;
    send_beats(8'h0A, {32'h00000008, 32'h00000007, 32'h00000006, 32'h00000005}, 4, 1'b0,
               128'h00000008_00000007_00000006_00000005);
    repeat (4) @(posedge clk);
    #1;

    check("pending_writes", DW'(wr_q.size()), DW'(0));
    check("pending_crit",   DW'(crit_q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
